// File: rtl/mult_hilo_unit.sv
// mult_hilo_unit: sequential radix-2 shift-add multiplier for MULT/MULTU.
// The operands come from the register-file read ports. The 2*WIDTH-bit
// product is written to the HI/LO registers, which the MFHI/MFLO write-back
// path reads.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; has priority over everything else
//   start      request a multiply; ignored while busy
//   is_signed  1 = MULT (two's complement), 0 = MULTU; captured with start
//   operand_a  multiplicand (register-file read_data1)
//   operand_b  multiplier   (register-file read_data2)
//   busy       high while iterating (state RUN)
//   done       one-cycle pulse; hi/lo hold the new product in this cycle
//   hi, lo     upper/lower halves of the last completed product
module mult_hilo_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_acc;
  logic               r_neg;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic               w_neg;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_result;
  logic [2*WIDTH-1:0] w_final;

  always_comb begin
    // Negating -2^(WIDTH-1) gives 2^(WIDTH-1). That value is correct when
    // the result is read as unsigned, so this step cannot overflow.
    w_abs_a = (is_signed && operand_a[WIDTH-1]) ? (~operand_a + WIDTH'(1)) : operand_a;
    w_abs_b = (is_signed && operand_b[WIDTH-1]) ? (~operand_b + WIDTH'(1)) : operand_b;
    w_neg   = is_signed & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);

    // Add with one extra bit so the carry is kept.
    w_sum = {1'b0, r_acc} + (r_mplier[0] ? {1'b0, r_mcand} : '0);

    // {carry, acc, multiplier} shifted right by one. This is the full
    // product once the last iteration completes.
    w_result = {w_sum, r_mplier[WIDTH-1:1]};
    w_final  = r_neg ? (~w_result + (2*WIDTH)'(1)) : w_result;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_mcand  <= w_abs_a;
            r_mplier <= w_abs_b;
            r_neg    <= w_neg;
            r_acc    <= '0;
            r_cnt    <= CW'(WIDTH);
            r_state  <= RUN;
          end else begin
            r_state  <= IDLE;
          end
        end
        RUN: begin
          r_acc    <= w_sum[WIDTH:1];
          r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
          r_cnt    <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_hi    <= w_final[2*WIDTH-1:WIDTH];
            r_lo    <= w_final[WIDTH-1:0];
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
